// File: rtl/product_of_sum_scheduler.sv
// rtl/product_of_sum_scheduler.sv - round-robin scheduler for f=(x|~w)&(y|w)
// Four requesters share one evaluator; a start pulse runs a 16-vector truth-table sweep.
module product_of_sum_scheduler #(
  parameter int SWEEP_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] din,
  output logic [3:0]  gnt,
  output logic        res_valid,
  output logic        res_f,
  output logic [1:0]  res_id,
  input  logic        res_ready,
  input  logic        start,
  output logic        sweep_done,
  output logic [4:0]  ones_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  ones_q, ones_d;
  logic        res_valid_q, res_valid_d;
  logic        res_f_q, res_f_d;
  logic [1:0]  res_id_q, res_id_d;
  logic [3:0]  gnt_c;
  logic        found;
  logic [1:0]  sel;
  logic [1:0]  cand;
  logic        stall;

  // Operand nibble is {w,z,y,x}; z is deliberately unused.
  function automatic logic pos_f(input logic [3:0] v);
    return (v[0] | ~v[3]) & (v[1] | v[3]);
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    ones_d      = ones_q;
    res_valid_d = res_valid_q;
    res_f_d     = res_f_q;
    res_id_d    = res_id_q;
    gnt_c       = 4'b0000;
    found       = 1'b0;
    sel         = 2'd0;
    cand        = 2'd0;
    stall       = res_valid_q & ~res_ready;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if ((SWEEP_EN != 0) && start) begin
          state_d = SWEEP;
          idx_d   = 4'd0;
          ones_d  = 5'd0;
        end else if (!stall && !rst) begin
          for (int k = 0; k < 4; k++) begin
            cand = ptr_q + k[1:0];
            if (!found && req[cand]) begin
              found = 1'b1;
              sel   = cand;
            end
          end
          if (found) begin
            gnt_c[sel]  = 1'b1;
            ptr_d       = sel + 2'd1;
            res_valid_d = 1'b1;
            res_f_d     = pos_f(din[{sel, 2'b00} +: 4]);
            res_id_d    = sel;
          end
        end
      end
      SWEEP: begin
        ones_d = ones_q + {4'b0000, pos_f(idx_q)};
        idx_d  = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      idx_q       <= 4'd0;
      ones_q      <= 5'd0;
      res_valid_q <= 1'b0;
      res_f_q     <= 1'b0;
      res_id_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      ones_q      <= ones_d;
      res_valid_q <= res_valid_d;
      res_f_q     <= res_f_d;
      res_id_q    <= res_id_d;
    end
  end

  assign gnt        = gnt_c;
  assign res_valid  = res_valid_q;
  assign res_f      = res_f_q;
  assign res_id     = res_id_q;
  assign sweep_done = (state_q == DONE);
  assign ones_count = ones_q;

endmodule

// File: tb/tb_product_of_sum_scheduler.sv
// tb/tb_product_of_sum_scheduler.sv - scoreboard bench for product_of_sum_scheduler
// Directed vectors; a negedge monitor pops expected {id,f} on every result take.
module tb_product_of_sum_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] din;
  logic        res_ready;
  logic        start;

  logic [3:0]  gnt;
  logic        res_valid;
  logic        res_f;
  logic [1:0]  res_id;
  logic        sweep_done;
  logic [4:0]  ones_count;

  logic [3:0]  gnt0;
  logic        res_valid0;
  logic        res_f0;
  logic [1:0]  res_id0;
  logic        sweep_done0;
  logic [4:0]  ones_count0;

  int          errors;
  int          checks;
  logic [2:0]  exp_q[$];
  logic [2:0]  popped;
  logic        sd0_seen;

  product_of_sum_scheduler #(.SWEEP_EN(1)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt),
    .res_valid(res_valid), .res_f(res_f), .res_id(res_id),
    .res_ready(res_ready), .start(start), .sweep_done(sweep_done),
    .ones_count(ones_count)
  );

  product_of_sum_scheduler #(.SWEEP_EN(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt0),
    .res_valid(res_valid0), .res_f(res_f0), .res_id(res_id0),
    .res_ready(res_ready), .start(start), .sweep_done(sweep_done0),
    .ones_count(ones_count0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sweep_done0 === 1'b1) sd0_seen <= 1'b1;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id=%0d f=%0d expected none", res_id, res_f);
      end else begin
        popped = exp_q.pop_front();
        chk("result_id_f", {29'd0, res_id, res_f}, {29'd0, popped});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    errors    = 0;
    checks    = 0;
    sd0_seen  = 1'b0;
    rst       = 1'b1;
    req       = 4'hF;
    din       = 16'h0000;
    res_ready = 1'b1;
    start     = 1'b0;

    // reset state
    mid();
    chk("gnt_in_reset", {28'd0, gnt}, 32'd0);
    adv();
    rst = 1'b0;
    req = 4'b0000;
    mid();
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_f_id", {29'd0, res_id, res_f}, 32'd0);
    chk("rst_ones_count", {27'd0, ones_count}, 32'd0);
    chk("rst_sweep_done", {31'd0, sweep_done}, 32'd0);

    // single request, f=1 then f=0 back-to-back with take
    adv();
    req = 4'b0100;
    din = 16'h0200;
    mid();
    chk("single_gnt", {28'd0, gnt}, 32'h4);
    exp_q.push_back({2'd2, 1'b1});
    adv();
    din = 16'h0800;
    mid();
    chk("single_res_valid", {31'd0, res_valid}, 32'd1);
    chk("single_gnt2", {28'd0, gnt}, 32'h4);
    exp_q.push_back({2'd2, 1'b0});
    adv();
    req = 4'b0000;
    mid();
    chk("single_res_f0", {31'd0, res_f}, 32'd0);

    // fairness from ptr=0; nibbles 0..3 = 2,8,9,1 -> f = 1,0,1,0
    adv();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    req = 4'hF;
    din = 16'h1982;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("fair_gnt", {28'd0, gnt}, 32'd1 << (k % 4));
      exp_q.push_back({2'(k % 4), ((k % 2) == 0) ? 1'b1 : 1'b0});
      adv();
    end

    // backpressure: result {0,1} held, req[0] waits
    req = 4'b0001;
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("bp_gnt", {28'd0, gnt}, 32'd0);
      chk("bp_hold", {29'd0, res_valid, res_id}, {29'd0, 1'b1, 2'd0});
      chk("bp_f", {31'd0, res_f}, 32'd1);
      adv();
    end
    res_ready = 1'b1;
    mid();
    chk("bp_release_gnt", {28'd0, gnt}, 32'h1);
    exp_q.push_back({2'd0, 1'b1});
    adv();
    req = 4'b0000;
    mid();
    chk("bp_new_valid", {31'd0, res_valid}, 32'd1);
    adv();
    mid();
    chk("idle_valid_clear", {31'd0, res_valid}, 32'd0);

    // sweep
    adv();
    start = 1'b1;
    adv();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      mid();
      chk("sweep_no_done", {31'd0, sweep_done}, 32'd0);
      adv();
    end
    mid();
    chk("sweep_done_pulse", {31'd0, sweep_done}, 32'd1);
    chk("sweep_ones_done", {27'd0, ones_count}, 32'd8);
    adv();
    mid();
    chk("sweep_done_clear", {31'd0, sweep_done}, 32'd0);
    adv();
    adv();
    mid();
    chk("ones_held", {27'd0, ones_count}, 32'd8);
    chk("no_sweep_en0_ones", {27'd0, ones_count0}, 32'd0);

    // collision: start wins, req[1] served after DONE; extra start mid-sweep ignored
    adv();
    start = 1'b1;
    req   = 4'b0010;
    din   = 16'h0030;
    mid();
    chk("coll_gnt", {28'd0, gnt}, 32'd0);
    chk("coll_gnt_en0", {28'd0, gnt0}, 32'h2);
    adv();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      start = (k == 5) ? 1'b1 : 1'b0;
      mid();
      chk("coll_sweep_gnt", {28'd0, gnt}, 32'd0);
      adv();
    end
    start = 1'b0;
    mid();
    chk("coll_done", {31'd0, sweep_done}, 32'd1);
    chk("coll_done_gnt", {28'd0, gnt}, 32'd0);
    adv();
    mid();
    chk("coll_after_gnt", {28'd0, gnt}, 32'h2);
    exp_q.push_back({2'd1, 1'b1});
    adv();
    req = 4'b0000;

    // reset at 8th sweep cycle with a result pending
    adv();
    req       = 4'b0100;
    din       = 16'h0200;
    res_ready = 1'b0;
    mid();
    chk("pend_gnt", {28'd0, gnt}, 32'h4);
    adv();
    req   = 4'b0000;
    start = 1'b1;
    adv();
    start = 1'b0;
    for (int k = 0; k < 7; k++) adv();
    rst = 1'b1;
    mid();
    chk("pre_rst_pending", {31'd0, res_valid}, 32'd1);
    adv();
    rst = 1'b0;
    mid();
    chk("post_rst_outs", {21'd0, gnt, res_valid, res_f, res_id, sweep_done},
        32'd0);
    chk("post_rst_ones", {27'd0, ones_count}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      mid();
      chk("no_done_after_abort", {31'd0, sweep_done}, 32'd0);
      adv();
    end
    req       = 4'hF;
    din       = 16'h1982;
    res_ready = 1'b1;
    mid();
    chk("ptr_restart_gnt", {28'd0, gnt}, 32'h1);
    exp_q.push_back({2'd0, 1'b1});
    adv();
    req = 4'b0000;
    adv();
    adv();
    mid();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("en0_never_done", {31'd0, sd0_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
